// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants and types for the single-cycle CPU datapath
//               (register file, ALU and decode stages).
//               DATA_W   - datapath / register width in bits
//               ADDR_W   - register address width
//               NUM_REGS - architectural register count (2**ADDR_W)
//               ZERO_REG - address of the hardwired-zero register
//               word_t   - one datapath word
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [DATA_W-1:0] word_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/reg_file_read_port.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_read_port
// Description : One combinational read port of the register file. Selects a
//               word out of the flattened register image, forces address 0
//               to zero and, when REGFILE_BYPASS_EN is defined, forwards the
//               in-flight write data on an address match.
// Ports       : i_addr  - read address
//               i_regs  - flattened register image, word k at [k*DATA_W +: DATA_W]
//               i_rst   - reset (suppresses forwarding)
//               i_we    - write enable of the write port
//               i_wa    - write address of the write port
//               i_wd    - write data of the write port
//               o_rdata - read data
// Macro       : REGFILE_BYPASS_EN - enables write-to-read forwarding
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_read_port
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
    input  logic [ADDR_W-1:0]          i_addr,
    input  logic [NUM_REGS*DATA_W-1:0] i_regs,
    input  logic                       i_rst,
    input  logic                       i_we,
    input  logic [ADDR_W-1:0]          i_wa,
    input  logic [DATA_W-1:0]          i_wd,
    output logic [DATA_W-1:0]          o_rdata
);

    localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] w_stored;
    logic              w_is_zero;

    assign w_stored  = i_regs[i_addr*DATA_W +: DATA_W];
    assign w_is_zero = (i_addr == c_zero_addr);

`ifdef REGFILE_BYPASS_EN
    logic w_fwd;

    // Forward only a write that will actually land on this edge.
    assign w_fwd = i_we && !i_rst && (i_wa == i_addr) && !w_is_zero;

    always_comb begin
        o_rdata = w_stored;
        if (w_is_zero) begin
            o_rdata = '0;
        end else if (w_fwd) begin
            o_rdata = i_wd;
        end
    end
`else
    // Write-port inputs only matter for forwarding.
    logic w_unused;
    assign w_unused = &{1'b0, i_rst, i_we, i_wa, i_wd};

    always_comb begin
        o_rdata = w_stored;
        if (w_is_zero) begin
            o_rdata = '0;
        end
    end
`endif

endmodule : reg_file_read_port
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : Architectural register file, 2 combinational read ports and
//               1 clocked write port. Register 0 is hardwired to zero.
// Ports       : clk   - system clock, rising-edge state updates
//               reset - synchronous active-high reset, clears regs 1..N-1
//               A1/A2 - read addresses
//               A3    - write address
//               WE3   - write enable
//               WD3   - write data
//               RD1   - read data port 1 (ALU SrcA)
//               RD2   - read data port 2 (SrcB mux)
// Macro       : REGFILE_BYPASS_EN - same-cycle write-to-read forwarding
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic              WE3,
    input  logic [DATA_W-1:0] WD3,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2
);

    localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(ZERO_REG);

    if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_cfg
        $error("reg_file: NUM_REGS must equal 2**ADDR_W");
    end

    // Register 0 has no storage; its slot in the read image is tied to zero.
    logic [DATA_W-1:0]          r_regs [NUM_REGS-1:1];
    logic [NUM_REGS*DATA_W-1:0] w_regs_flat;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (WE3 && (A3 != c_zero_addr)) begin
            r_regs[A3] <= WD3;
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        if (gi == 0) begin : g_zero
            assign w_regs_flat[gi*DATA_W +: DATA_W] = '0;
        end else begin : g_reg
            assign w_regs_flat[gi*DATA_W +: DATA_W] = r_regs[gi];
        end
    end

    reg_file_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_rd1 (
        .i_addr  (A1),
        .i_regs  (w_regs_flat),
        .i_rst   (reset),
        .i_we    (WE3),
        .i_wa    (A3),
        .i_wd    (WD3),
        .o_rdata (RD1)
    );

    reg_file_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_rd2 (
        .i_addr  (A2),
        .i_regs  (w_regs_flat),
        .i_rst   (reset),
        .i_we    (WE3),
        .i_wa    (A3),
        .i_wd    (WD3),
        .o_rdata (RD2)
    );

endmodule : reg_file
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Self-checking bench for reg_file. Directed scenarios plus
//               random traffic, compared against an array-based model of the
//               register file. Honours REGFILE_BYPASS_EN for same-cycle reads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic [4:0]  A1, A2, A3;
    logic        WE3;
    logic [31:0] WD3;
    logic [31:0] RD1, RD2;

    int n_checks;
    int n_pass;

    // Reference model: contents of registers 1..31 (index 0 unused).
    logic [31:0] mem [32];

    reg_file dut (
        .clk   (clk),
        .reset (reset),
        .A1    (A1),
        .A2    (A2),
        .A3    (A3),
        .WE3   (WE3),
        .WD3   (WD3),
        .RD1   (RD1),
        .RD2   (RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Value a read port should show while the current inputs are applied.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (WE3 && !reset && (A3 == a)) return WD3;
`endif
        return mem[a];
    endfunction

    // Apply one cycle of inputs, check both read ports before the edge,
    // then advance the model across the edge.
    task automatic cycle(input logic rst, input logic we, input logic [4:0] a3,
                         input logic [31:0] wd, input logic [4:0] a1,
                         input logic [4:0] a2, input string tag);
        reset = rst;
        WE3   = we;
        A3    = a3;
        WD3   = wd;
        A1    = a1;
        A2    = a2;
        @(negedge clk);
        check($sformatf("%s rd1[%0d]", tag, a1), RD1, exp_read(a1));
        check($sformatf("%s rd2[%0d]", tag, a2), RD2, exp_read(a2));
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        end else if (we && a3 != 5'd0) begin
            mem[a3] = wd;
        end
        #1;
    endtask

    initial begin
        int targets [4];
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1;
        WE3   = 1'b0;
        A1    = 5'd0;
        A2    = 5'd0;
        A3    = 5'd0;
        WD3   = 32'h0;

        // Register 0 reads zero even before any reset.
        #1;
        check("prereset_zero_rd1", RD1, 32'h0);
        check("prereset_zero_rd2", RD2, 32'h0);

        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "init_reset");

        // Reset after preload clears the register.
        targets = '{5, 1, 16, 31};
        foreach (targets[k]) begin
            logic [4:0] r;
            r = 5'(targets[k]);
            cycle(1'b0, 1'b1, r, 32'hDEADBEEF, 5'd0, 5'd0, "preload");
            cycle(1'b0, 1'b0, 5'd0, 32'h0, r, r, "preload_rd");
            check("preload_val", mem[r], 32'hDEADBEEF);
            cycle(1'b1, 1'b0, 5'd0, 32'h0, r, 5'd0, "reset");
            cycle(1'b0, 1'b0, 5'd0, 32'h0, r, r, "after_reset");
        end

        // Basic write/read and ALU-sum sanity.
        cycle(1'b0, 1'b1, 5'd9, 32'd9, 5'd0, 5'd0, "wr9");
        A1 = 5'd9;
        A2 = 5'd9;
        WE3 = 1'b0;
        @(negedge clk);
        check("alu_add", RD1 + RD2, 32'd18);
        check("rd1_9", RD1, 32'd9);
        @(posedge clk);
        #1;

        // Writes to register 0 are dropped.
        cycle(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "wr0");
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "rd0");

        // Collision: old value before the edge (or forwarded), new after.
        cycle(1'b0, 1'b1, 5'd3, 32'd5, 5'd0, 5'd0, "wr3");
        cycle(1'b0, 1'b1, 5'd3, 32'd7, 5'd3, 5'd3, "collide");
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, "post_collide");
        check("collide_new", RD1, 32'd7);

        // Reset beats a simultaneous write.
        cycle(1'b0, 1'b1, 5'd4, 32'h55, 5'd0, 5'd0, "wr4");
        cycle(1'b1, 1'b1, 5'd4, 32'h1234, 5'd4, 5'd0, "rst_vs_wr");
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4, "rst_prio");

        // Sweep: reg[i] = 3*i, then read complementary pairs.
        for (int i = 1; i < 32; i++) begin
            cycle(1'b0, 1'b1, 5'(i), 32'(i * 3), 5'd0, 5'd0, "sweep_wr");
        end
        for (int i = 1; i < 32; i++) begin
            reset = 1'b0;
            WE3   = 1'b0;
            A1    = 5'(i);
            A2    = 5'(32 - i);
            @(negedge clk);
            check($sformatf("sweep rd1[%0d]", i), RD1, 32'(i * 3));
            check($sformatf("sweep rd2[%0d]", 32 - i), RD2, 32'((32 - i) * 3));
            @(posedge clk);
            #1;
        end

        // Random traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            logic rst_r;
            logic we_r;
            rst_r = ($urandom_range(0, 31) == 0);
            we_r  = ($urandom_range(0, 3) != 0);
            cycle(rst_r, we_r, 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rand");
        end

        // Final readback of every register on both ports.
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "final");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_reg_file
`default_nettype wire

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file for the single-cycle CPU, directly upstream of the ALU.
- RD1 drives ALU SrcA; RD2 drives the register-sourced SrcB path.
- Stores 32 x 32-bit registers with two combinational read ports and one clocked write port.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register and data-port width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, register count; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- A1  input  ADDR_W  read address, port 1
- A2  input  ADDR_W  read address, port 2
- A3  input  ADDR_W  write address
- WE3  input  1  write enable
- WD3  input  DATA_W  write data
- RD1  output  DATA_W  read data, port 1 (feeds ALU SrcA)
- RD2  output  DATA_W  read data, port 2 (feeds SrcB mux)

Behaviour:
- Reset: on a rising edge with reset=1, all registers 1..31 clear to 0. The clear completes in that single edge.
  - RD1 and RD2 read 0 for every address from the following cycle onward.
  - Reset takes priority over WE3 in the same cycle; the write is dropped.
- Write: on a rising edge with reset=0, WE3=1 and A3!=0, reg[A3] <= WD3.
  - A write to A3=0 is silently ignored.
  - WE3=0 leaves all state unchanged.
- Read: RD1 = reg[A1] and RD2 = reg[A2], purely combinational with zero-cycle latency.
  - Address 0 always reads 32'h0.
  - A1 and A2 may be equal; both ports then return the same value.
- Read/write collision (A1 or A2 equals A3, WE3=1, no bypass): the read returns the pre-edge (old) value until the edge, and the new value afterwards.
- No X propagation after reset: every register has a defined value once reset has been applied.
- Before the first reset, register contents are undefined. Register 0 still reads 0.
- Reset asserted mid-sequence clears everything regardless of pending writes. No partial state is retained.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. When WE3=1, reset=0, A3!=0 and A1==A3, RD1 = WD3 combinationally in the same cycle. RD2 behaves the same way against A2.
- Address 0 is never bypassed. The stored result is identical with or without the macro.
- Undefined: reads return stored values only, as described under Read/write collision.

Decomposition:
- Shared package cpu_pkg holds DATA_W, ADDR_W, NUM_REGS, the constant ZERO_REG = 5'd0, and typedef word_t (logic [DATA_W-1:0]). The ALU and later decode stages use the same package.
- One natural sub-module: reg_file_read_port, containing the address decode, the zero-register force and the optional bypass mux. It is instantiated twice, for A1/RD1 and A2/RD2.
- The storage array and write logic stay in reg_file.

Test Plan:
- Reset: preload reg5 = 32'hDEADBEEF, then assert reset for 1 cycle -> RD1 with A1=5 reads 0. Repeat for registers 1, 16 and 31.
- Basic write/read: WE3=1, A3=9, WD3=32'd9, one edge; then A1=9, A2=9 -> RD1 = RD2 = 9, so the ALU add of RD1+RD2 gives 18.
- Zero register: WE3=1, A3=0, WD3=32'hFFFFFFFF, one edge -> RD1 with A1=0 reads 0.
- Collision, bypass undefined: reg3 = 5; in one cycle A1=3, A3=3, WE3=1, WD3=7 -> RD1=5 before the edge, 7 after. With REGFILE_BYPASS_EN defined -> RD1=7 before the edge.
- Reset priority: reset=1, WE3=1, A3=4, WD3=32'h1234 on the same edge -> reg4 reads 0 afterwards.
- Sweep: write reg[i] = i*3 for i = 1..31, then read every pair (i, 32-i) -> exact values on both ports, and no register aliasing.
